// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline sequencing controller.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package pipe_ctrl_pkg;

   // Sequencer states: normal issue, wrong-path squash, halt drain, parked.
   typedef enum logic [1:0] {
      RUN    = 2'd0,
      FLUSH  = 2'd1,
      DRAIN  = 2'd2,
      HALTED = 2'd3
   } pipe_state_e;

   // Per-stage register controls, MSB first in port order.
   typedef struct packed {
      logic pc_en;
      logic redirect;
      logic if_id_en;
      logic if_id_flush;
      logic id_ex_en;
      logic id_ex_bubble;
      logic ex_mem_en;
      logic mem_wb_en;
   } stage_ctrl_t;

   localparam int DEF_FLUSH_CYCLES = 1;
   localparam int DEF_DRAIN_CYCLES = 4;
   localparam int DEF_HZ_TIMEOUT   = 64;
   localparam int DEF_CNT_W        = 32;

   // Canned control words for the common cases.
   localparam stage_ctrl_t CTRL_IDLE   = stage_ctrl_t'(8'b0000_0000);
   localparam stage_ctrl_t CTRL_RUN    = stage_ctrl_t'(8'b1010_1011);
   localparam stage_ctrl_t CTRL_HZ     = stage_ctrl_t'(8'b0000_1111);
   localparam stage_ctrl_t CTRL_BRANCH = stage_ctrl_t'(8'b1111_1111);
   localparam stage_ctrl_t CTRL_FLUSH  = stage_ctrl_t'(8'b1011_1011);
   localparam stage_ctrl_t CTRL_DRAIN  = stage_ctrl_t'(8'b0011_1011);

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter, sticks at all-ones.
// Latency: count reflects inc one clock later.
// Backpressure: none; inc is sampled every cycle.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // Count up on inc until all-ones, then hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencer: stage enables/flush/bubble/redirect, halt drain, perf counters, hazard watchdog.
// Latency: stage controls combinational from state and inputs; state/counters/flags update next clock.
// Backpressure: a pending data-memory access (dmem_req && !dmem_ready) freezes every stage.
module pipe_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
   parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
   parameter int HZ_TIMEOUT   = DEF_HZ_TIMEOUT,
   parameter int CNT_W        = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hz,
   input  logic             branch_taken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   input  logic             halt_req,
   output logic             pc_en,
   output logic             redirect,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_ex_en,
   output logic             id_ex_bubble,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count,
   output logic             hz_timeout_err
);

   localparam int FW = $clog2(FLUSH_CYCLES + 1);
   localparam int DW = $clog2(DRAIN_CYCLES + 1);
   localparam int HW = $clog2(HZ_TIMEOUT + 1);

   pipe_state_e     state, state_nxt;
   logic [FW-1:0]   flush_cnt, flush_nxt;
   logic [DW-1:0]   drain_cnt, drain_nxt;
   logic [HW-1:0]   hz_run_cnt;
   stage_ctrl_t     ctl;
   logic            frozen;
   logic            stall_inc;

   assign frozen = dmem_req && !dmem_ready;

   // State and down-counter registers; reset always lands in RUN with nothing pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         flush_cnt <= '0;
         drain_cnt <= '0;
      end else begin
         state     <= state_nxt;
         flush_cnt <= flush_nxt;
         drain_cnt <= drain_nxt;
      end
   end

   // Next state and stage controls; priority is freeze, branch, hazard, halt.
   always_comb begin
      ctl       = CTRL_IDLE;
      state_nxt = state;
      flush_nxt = flush_cnt;
      drain_nxt = drain_cnt;
      stall_inc = 1'b0;
      if (frozen && (state != HALTED)) begin
         // Memory not ready: nothing moves, sequencing waits.
         stall_inc = 1'b1;
      end else begin
         case (state)
            RUN: begin
               if (branch_taken) begin
                  // ID holds a wrong-path instruction, so hz is irrelevant here.
                  ctl = CTRL_BRANCH;
                  if (FLUSH_CYCLES > 1) begin
                     state_nxt = FLUSH;
                     flush_nxt = FW'(FLUSH_CYCLES - 1);
                  end
               end else if (hz) begin
                  ctl       = CTRL_HZ;
                  stall_inc = 1'b1;
               end else begin
                  ctl = CTRL_RUN;
                  if (halt_req) begin
                     state_nxt = DRAIN;
                     drain_nxt = DW'(DRAIN_CYCLES);
                  end
               end
            end
            FLUSH: begin
               ctl = CTRL_FLUSH;
               if (branch_taken) begin
                  // Fresh redirect restarts the squash window.
                  ctl.redirect     = 1'b1;
                  ctl.id_ex_bubble = 1'b1;
                  flush_nxt        = FW'(FLUSH_CYCLES - 1);
               end else if (flush_cnt <= FW'(1)) begin
                  state_nxt = RUN;
               end else begin
                  flush_nxt = flush_cnt - FW'(1);
               end
            end
            DRAIN: begin
               if (!branch_taken && hz) begin
                  // Stalled drain cycles do not empty the pipe.
                  ctl       = CTRL_HZ;
                  stall_inc = 1'b1;
               end else begin
                  ctl = CTRL_DRAIN;
                  if (branch_taken) begin
                     ctl.redirect     = 1'b1;
                     ctl.pc_en        = 1'b1;
                     ctl.id_ex_bubble = 1'b1;
                  end
                  if (drain_cnt <= DW'(1)) begin
                     state_nxt = HALTED;
                  end else begin
                     drain_nxt = drain_cnt - DW'(1);
                  end
               end
            end
            HALTED: begin
               if (!halt_req) begin
                  state_nxt = RUN;
               end
            end
            default: begin
               state_nxt = RUN;
            end
         endcase
      end
      // Enables must be low throughout reset regardless of inputs.
      if (!rst_n) begin
         ctl = CTRL_IDLE;
      end
   end

   assign pc_en        = ctl.pc_en;
   assign redirect     = ctl.redirect;
   assign if_id_en     = ctl.if_id_en;
   assign if_id_flush  = ctl.if_id_flush;
   assign id_ex_en     = ctl.id_ex_en;
   assign id_ex_bubble = ctl.id_ex_bubble;
   assign ex_mem_en    = ctl.ex_mem_en;
   assign mem_wb_en    = ctl.mem_wb_en;
   assign halted       = (state == HALTED);

   // Watchdog: run length of consecutive hz cycles; flag latches when it reaches the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hz_run_cnt     <= '0;
         hz_timeout_err <= 1'b0;
      end else begin
         if (!hz) begin
            hz_run_cnt <= '0;
         end else if (hz_run_cnt != HW'(HZ_TIMEOUT)) begin
            hz_run_cnt <= hz_run_cnt + HW'(1);
         end
         if (hz && (hz_run_cnt == HW'(HZ_TIMEOUT - 1))) begin
            hz_timeout_err <= 1'b1;
         end
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_inc),
      .count (stall_cycles)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (ctl.redirect),
      .count (flush_count)
   );

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Pipeline sequencing controller for the Mini-RISC-V 5-stage core.
- Consumes the decode-stage hazard flag, EX branch resolution, the data-memory ready handshake and a debug halt request.
- Drives per-stage register enables, flush and bubble controls, and the PC redirect.
- Owns flush sequencing, halt drain, stall/flush performance counters and a hazard-lock watchdog.

Parameters:
- FLUSH_CYCLES, 1, wrong-path fetch slots to squash after a redirect (≥1).
- DRAIN_CYCLES, 4, committed non-stalled cycles needed to empty the pipe before halting.
- HZ_TIMEOUT, 64, consecutive hz cycles that trip the watchdog.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- hz  in  1  decode hazard (stall IF/ID, bubble ID/EX).
- branch_taken  in  1  EX resolved a taken branch or jump.
- dmem_req  in  1  MEM-stage load/store active.
- dmem_ready  in  1  data memory completes this cycle.
- halt_req  in  1  debug halt request, level.
- pc_en  out  1  PC register load enable.
- redirect  out  1  PC mux selects EX target.
- if_id_en  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID loads NOP.
- id_ex_en  out  1  ID/EX load enable.
- id_ex_bubble  out  1  ID/EX loads NOP (control bits cleared).
- ex_mem_en  out  1  EX/MEM load enable.
- mem_wb_en  out  1  MEM/WB load enable.
- halted  out  1  core parked.
- stall_cycles  out  CNT_W  saturating stall counter.
- flush_count  out  CNT_W  saturating redirect counter.
- hz_timeout_err  out  1  sticky watchdog flag.

Behaviour:
- FSM states: RUN, FLUSH, DRAIN, HALTED. Reset state RUN.
- Reset (rst_n low, async): counters, flush_cnt, drain_cnt and hz_run_cnt = 0; hz_timeout_err = 0; halted = 0; all enables = 0.
- Stage-control outputs are combinational from state and inputs. Counters, flags and state are registered.
- frozen = dmem_req && !dmem_ready. Priority: frozen > branch_taken > hz > halt_req.
- frozen (any state except HALTED): all enables 0, flush/bubble/redirect 0, state and down-counters hold.
- RUN, default: all enables 1.
- RUN + branch_taken:
  - redirect=1, pc_en=1, if_id_flush=1, id_ex_bubble=1, ex_mem_en=mem_wb_en=1.
  - hz is ignored (ID holds a wrong-path instruction).
  - If FLUSH_CYCLES>1: go to FLUSH with flush_cnt=FLUSH_CYCLES-1.
- RUN + hz (no branch): pc_en=0, if_id_en=0, id_ex_bubble=1, ex_mem_en=mem_wb_en=1.
- RUN + halt_req (none of the above): go to DRAIN with drain_cnt=DRAIN_CYCLES. This cycle advances normally.
- FLUSH:
  - pc_en=1, if_id_flush=1, other stages advance, hz ignored.
  - flush_cnt decrements; at 1, return to RUN.
  - branch_taken reloads flush_cnt and asserts redirect.
- DRAIN:
  - pc_en=0, if_id_flush=1 unless hz. Under hz, RUN hz behaviour applies and drain_cnt holds.
  - Otherwise drain_cnt decrements; at 1, go to HALTED.
  - branch_taken: redirect=1, pc_en=1, id_ex_bubble=1; drain_cnt still decrements.
- HALTED: halted=1, all enables 0, frozen ignored. When halt_req=0, go to RUN next cycle.
- stall_cycles increments on every cycle where frozen, or (hz && state∈{RUN,DRAIN} && !branch_taken). Saturates at all-ones.
- flush_count increments on each redirect=1 cycle. Saturates at all-ones.
- Watchdog:
  - hz_run_cnt counts consecutive hz=1 cycles and clears on hz=0.
  - Reaching HZ_TIMEOUT sets hz_timeout_err, which is sticky until reset.
- A reset mid-DRAIN or mid-FLUSH aborts to RUN with no residual flush.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state enum pipe_state_e {RUN, FLUSH, DRAIN, HALTED};
  - struct stage_ctrl_t bundling the stage-control outputs;
  - default constants.
- One sub-module sat_counter (CNT_W, inc, rst_n), instantiated twice.

Test Plan:
- hz=1 one cycle in RUN → pc_en=0, if_id_en=0, id_ex_bubble=1, stall_cycles 0→1, next cycle all enables 1.
- branch_taken=1 with hz=1, FLUSH_CYCLES=2 → cycle0 redirect=1, if_id_flush=1, id_ex_bubble=1; cycle1 state FLUSH, if_id_flush=1; cycle2 RUN; flush_count=1.
- dmem_req=1, dmem_ready=0 for 3 cycles with branch_taken=1 → all enables 0 for 3 cycles, stall_cycles=3; on ready cycle, redirect=1.
- halt_req=1 in RUN with hz pulse mid-drain, DRAIN_CYCLES=4 → halted=1 after 4 non-hz DRAIN cycles (5 with one hz); halt_req=0 → RUN next cycle, pc_en=1.
- hz held 64 cycles → hz_timeout_err=1 on 64th, stays 1 after hz drops; rst_n pulse → 0.
- rst_n asserted mid-DRAIN → immediate all-zero outputs, counters 0; release → RUN, enables 1.
